seq_detect_scheduler: RTL and testbench
=======================================

# seq_detect_scheduler

Shares a single programmable overlapping sequence-detection engine among NCH serial bitstream requesters. A round-robin arbiter accepts at most one bit per cycle, and per-channel context (bit history, fill count) is kept so each stream is detected independently. It also provides per-channel Moore-style match pulses and saturating hit counters. It sits between the serial-input front ends and the status/interrupt logic, replacing one fixed-pattern detector instance per stream.

## Interface
- NCH, 4: number of requester channels (2..8)
- PAT_W, 4: pattern length in bits
- CNT_W, 8: hit counter width per channel
- RESET_PAT, 4'b1010: pattern value loaded at reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_load  in  1  load `pattern` this cycle, clear all channel contexts
- pattern  in  PAT_W  new pattern; MSB is the first bit of the sequence
- clr_cnt  in  1  synchronous clear of all hit counters
- req_valid  in  NCH  channel k offers a bit
- req_bit  in  NCH  serial bit of channel k
- req_ready  out  NCH  one-hot grant; transfer on k = req_valid[k] & req_ready[k]
- match  out  NCH  registered one-cycle pulse: channel k just completed the pattern
- hit_cnt  out  NCH*CNT_W  per-channel saturating match count; channel k at [k*CNT_W +: CNT_W]

## Operation
- Active pattern register `pat_q` resets to RESET_PAT. It is loaded from `pattern` when cfg_load=1.
- Per channel k: `hist_k` (PAT_W bits) and `fill_k` (0..PAT_W, saturating) are both 0 at reset.
- Arbitration is round-robin with pointer `ptr`, which resets to 0.
  - Grant goes to the first k with req_valid[k]=1, searching ptr, ptr+1, … modulo NCH.
  - After a grant to k, ptr becomes (k+1) mod NCH.
  - With no valid request, ptr holds and req_ready is all zeros.
- req_ready is combinational from req_valid, ptr and cfg_load. Requesters must not make req_valid depend on req_ready. Once asserted, valid and bit are held until the transfer completes.
- On transfer of bit b on channel k:
  - hist_k ← {hist_k[PAT_W-2:0], b}
  - fill_k ← min(fill_k+1, PAT_W)
- Match rule: the post-update hist_k == pat_q and the post-update fill_k == PAT_W. Detection is overlapping: history is never cleared on a match.
- match[k] is registered and set on the transfer edge, so it is high for exactly the following cycle. Non-granted channels show match=0.
- hit_cnt_k increments on the same edge that sets match[k] and saturates at 2^CNT_W−1.
- cfg_load=1:
  - req_ready is forced to 0, so no transfer occurs.
  - pat_q ← pattern; all hist, fill and match are cleared.
  - ptr and hit counters are unchanged.
- clr_cnt=1: all hit_cnt ← 0. If a match occurs on the same edge, clear wins (count = 0) and the match pulse still asserts.
- cfg_load and clr_cnt on the same cycle: both take effect.

## Timing
- Reset values: req_ready=0, match=0, hit_cnt=0, pat_q=RESET_PAT, ptr=0.
- Assertion of rst_n low mid-stream clears all state immediately, regardless of the clock.
- Accept-to-match latency is 1 cycle. match and hit_cnt update on the same edge.
- Throughput is one bit per cycle in aggregate. With all NCH channels valid continuously, each channel is granted exactly once every NCH cycles.
- A new pattern applies to bits transferred on the cycle after cfg_load. A channel needs PAT_W post-load bits before it can match.

## Structure
- Package `seq_det_pkg` holds:
  - defaults NCH_D=4, PAT_W_D=4, CNT_W_D=8, RESET_PAT_D=4'b1010
  - `ch_ctx_t` struct {hist, fill}
- Sub-module `rr_arbiter` (NCH-wide): inputs req, ptr and block; outputs one-hot grant and granted index. The top level owns ptr, contexts, pattern and counters.

## Test plan
- Reset defaults: rst_n low then high, channel 0 only, bits 1,0,1,0,1,0 → match[0] after the 4th and 6th bits (overlap); hit_cnt[0]=2; other channels 0.
- Round-robin fairness: all four req_valid held high for 8 cycles → grants 0,1,2,3,0,1,2,3. Drop channel 1 → sequence skips 1 and ptr rolls correctly.
- Independent contexts: channels 0 and 2 interleaved, each sending 1010 → each matches once, one cycle after its own 4th bit. A mixed-stream false match on channel 0 is absent.
- Reconfiguration: mid-stream on channel 0 after bits 1,0,1, pulse cfg_load with pattern=4'b1100. Then:
  - req_ready=0 that cycle;
  - sending 0 → no match (history cleared);
  - sending 1,1,0,0 → match.
- Saturation and clear: CNT_W=8, force 255 matches, then 1 more → hit_cnt stays 255. clr_cnt coincident with a match → hit_cnt=0 and match=1.
- Async reset mid-operation: assert rst_n between clock edges with pending history → match, hit_cnt and ready drop to 0 immediately; pat_q returns to 4'b1010.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the time-shared sequence detector.
package seq_det_pkg;

  localparam int unsigned NCH_D    = 4;
  localparam int unsigned PAT_W_D  = 4;
  localparam int unsigned CNT_W_D  = 8;
  localparam logic [PAT_W_D-1:0] RESET_PAT_D = 4'b1010;

  // Fill count must represent 0..PAT_W inclusive.
  localparam int unsigned FILL_W_D = $clog2(PAT_W_D + 1);

  // Per-channel detection context: recent bit history and how many bits it holds.
  typedef struct packed {
    logic [PAT_W_D-1:0]  hist;
    logic [FILL_W_D-1:0] fill;
  } ch_ctx_t;

  // Shift one bit into a context; fill saturates once the history is full.
  function automatic ch_ctx_t ctx_shift(ch_ctx_t c, logic b);
    ch_ctx_t r;
    r.hist = {c.hist[PAT_W_D-2:0], b};
    if (c.fill == FILL_W_D'(PAT_W_D)) begin
      r.fill = c.fill;
    end else begin
      r.fill = c.fill + FILL_W_D'(1);
    end
    return r;
  endfunction

  // A context matches when its history is full and equals the active pattern.
  function automatic logic ctx_match(ch_ctx_t c, logic [PAT_W_D-1:0] pat);
    return (c.fill == FILL_W_D'(PAT_W_D)) && (c.hist == pat);
  endfunction

endpackage

// File: rtl/seq_detect_scheduler_arb.sv
// Round-robin arbiter: first requester at or after ptr (mod NCH) wins, unless blocked.
module rr_arbiter #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned IDX_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             block,
  output logic [NCH-1:0]   grant_c,
  output logic [IDX_W-1:0] idx_c
);

  logic [IDX_W:0]   sum_c;
  logic [IDX_W-1:0] cand_c;
  logic             found_c;

  // Rotating priority search starting at ptr.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found_c = 1'b0;
    sum_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // ptr < NCH and i < NCH, so one conditional subtract gives the modulo.
      sum_c = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum_c >= (IDX_W+1)'(NCH)) begin
        sum_c = sum_c - (IDX_W+1)'(NCH);
      end
      cand_c = sum_c[IDX_W-1:0];
      if (!block && !found_c && req[cand_c]) begin
        grant_c[cand_c] = 1'b1;
        idx_c           = cand_c;
        found_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// One programmable overlapping sequence detector time-shared across NCH serial
// streams, with per-channel history, match pulses and saturating hit counters.
module seq_detect_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned      NCH       = NCH_D,
  parameter int unsigned      PAT_W     = PAT_W_D,
  parameter int unsigned      CNT_W     = CNT_W_D,
  parameter logic [PAT_W-1:0] RESET_PAT = RESET_PAT_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  input  logic [PAT_W-1:0]     pattern,
  input  logic                 clr_cnt,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_bit,
  output logic [NCH-1:0]       req_ready,
  output logic [NCH-1:0]       match,
  output logic [NCH*CNT_W-1:0] hit_cnt
);

  localparam int unsigned      IDX_W    = $clog2(NCH);
  localparam int unsigned      FILL_W   = FILL_W_D;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // The shared context type is sized by the package default pattern width.
  if (PAT_W != PAT_W_D) begin : g_bad_pat_w
    $error("seq_detect_scheduler: PAT_W must equal seq_det_pkg::PAT_W_D");
  end

  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] ptr_q;
  ch_ctx_t          ctx_q [NCH];
  logic [NCH-1:0]   match_q;
  logic [CNT_W-1:0] cnt_q [NCH];

  logic [NCH-1:0]   grant_c;
  logic [IDX_W-1:0] gnt_idx_c;
  logic             gnt_any_c;
  logic             arb_block_c;
  logic [IDX_W-1:0] ptr_nxt_c;
  ch_ctx_t          ctx_nxt_c [NCH];
  logic [NCH-1:0]   hit_c;

  // No grant while reconfiguring or while held in reset.
  assign arb_block_c = cfg_load | ~rst_n;

  rr_arbiter #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .block   (arb_block_c),
    .grant_c (grant_c),
    .idx_c   (gnt_idx_c)
  );

  assign req_ready = grant_c;
  assign match     = match_q;
  assign gnt_any_c = |grant_c;
  assign ptr_nxt_c = (gnt_idx_c == LAST_IDX) ? '0 : gnt_idx_c + IDX_W'(1);

  // Candidate next context and match decision for every channel; only the granted one is used.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      ctx_nxt_c[k] = ctx_shift(ctx_q[k], req_bit[k]);
      hit_c[k]     = grant_c[k] && ctx_match(ctx_nxt_c[k], pat_q);
    end
  end

  // Active pattern and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= RESET_PAT;
      ptr_q <= '0;
    end else begin
      if (cfg_load) begin
        pat_q <= pattern;
      end
      if (gnt_any_c) begin
        ptr_q <= ptr_nxt_c;
      end
    end
  end

  // Channel contexts and one-cycle match pulses; a reload wipes all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        ctx_q[k] <= '0;
      end
      match_q <= '0;
    end else if (cfg_load) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        ctx_q[k] <= '0;
      end
      match_q <= '0;
    end else begin
      match_q <= hit_c;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (grant_c[k]) begin
          ctx_q[k] <= ctx_nxt_c[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    // Saturating hit counter; a synchronous clear beats a same-edge match.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[k] <= '0;
      end else if (clr_cnt) begin
        cnt_q[k] <= '0;
      end else if (hit_c[k] && (cnt_q[k] != CNT_MAX)) begin
        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end

    assign hit_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  // Grant is at most one-hot and never issued during a reload.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_no_grant_on_load: assert property (@(posedge clk) disable iff (!rst_n) cfg_load |-> (req_ready == '0));

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_seq_detect_scheduler;

  localparam int unsigned NCH   = 4;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam int          PMASK = (1 << PAT_W) - 1;

  logic                 clk       = 1'b0;
  logic                 rst_n     = 1'b1;
  logic                 cfg_load  = 1'b0;
  logic [PAT_W-1:0]     pattern   = '0;
  logic                 clr_cnt   = 1'b0;
  logic [NCH-1:0]       req_valid = '0;
  logic [NCH-1:0]       req_bit   = '0;
  logic [NCH-1:0]       req_ready;
  logic [NCH-1:0]       match;
  logic [NCH*CNT_W-1:0] hit_cnt;

  always #5 clk = ~clk;

  seq_detect_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .clr_cnt   (clr_cnt),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .match     (match),
    .hit_cnt   (hit_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: history kept as an integer of the last PAT_W bits,
  // plus a count of bits seen since the last reload/reset.
  int             m_pat;
  int             m_ptr;
  int             m_hist  [NCH];
  int             m_nbits [NCH];
  int             m_cnt   [NCH];
  logic [NCH-1:0] m_match;
  logic [NCH-1:0] m_ready;
  logic [NCH-1:0] last_ready;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pat   = 4'b1010;
    m_ptr   = 0;
    m_match = '0;
    m_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      m_hist[k] = 0; m_nbits[k] = 0; m_cnt[k] = 0;
    end
  endtask

  function automatic logic [NCH-1:0] model_grant(input logic [NCH-1:0] v, input logic ld, input int p);
    logic [NCH-1:0] g = '0;
    if (!ld) begin
      for (int i = 0; i < NCH; i++) begin
        int c = (p + i) % NCH;
        if (v[c] && g == '0) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    m_match = '0;
    if (cfg_load) begin
      m_pat = int'(pattern);
      for (int k = 0; k < NCH; k++) begin
        m_hist[k] = 0; m_nbits[k] = 0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (m_ready[k]) begin
          m_hist[k] = ((m_hist[k] << 1) | int'(req_bit[k])) & PMASK;
          m_nbits[k]++;
          if (m_nbits[k] >= PAT_W && m_hist[k] == m_pat) begin
            m_match[k] = 1'b1;
            if (m_cnt[k] < CMAX) m_cnt[k]++;
          end
          m_ptr = (k + 1) % NCH;
        end
      end
    end
    if (clr_cnt) begin
      for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    end
  endtask

  // Every-cycle comparison, on the falling edge, of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", int'(req_ready), int'(m_ready));
      check("match", int'(match), int'(m_match));
      for (int k = 0; k < NCH; k++)
        check($sformatf("hit_cnt[%0d]", k), int'(hit_cnt[k*CNT_W +: CNT_W]), m_cnt[k]);
    end
  end

  // One bus cycle: entered and left at 1 time unit after a rising edge.
  task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                       input logic ld, input logic [PAT_W-1:0] p, input logic clr);
    req_valid = v; req_bit = b; cfg_load = ld; pattern = p; clr_cnt = clr;
    m_ready = model_grant(v, ld, m_ptr);
    @(negedge clk);
    last_ready = req_ready;
    @(posedge clk);
    model_edge();
    #1;
    req_valid = '0; cfg_load = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic send(input int ch, input logic b);
    logic [NCH-1:0] v = '0;
    logic [NCH-1:0] bv = '0;
    v[ch] = 1'b1; bv[ch] = b;
    cycle(v, bv, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    req_valid = '1; req_bit = '0; cfg_load = 1'b0; clr_cnt = 1'b0; pattern = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", int'(req_ready), 0);
    check("rst_match", int'(match), 0);
    check("rst_hit_cnt", int'(hit_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    req_valid = '0;
    model_reset();
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0]   pv;
    logic [NCH-1:0]   pb;
    logic [PAT_W-1:0] rp;
    int               pulses;
    logic             b4 [4];

    // Reset defaults and overlapping detection on channel 0.
    do_reset();
    b4[0] = 1'b1; b4[1] = 1'b0; b4[2] = 1'b1; b4[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(0, b4[i % 4]);
      if (i == 3 || i == 5) check($sformatf("t1_match_bit%0d", i + 1), int'(match[0]), 1);
      else                  check($sformatf("t1_nomatch_bit%0d", i + 1), int'(match[0]), 0);
    end
    check("t1_hit_cnt0", int'(hit_cnt[0 +: CNT_W]), 2);
    check("t1_hit_cnt_others", int'(hit_cnt[NCH*CNT_W-1:CNT_W]), 0);

    // Round-robin fairness, then with channel 1 dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 4'b0000, 1'b0, '0, 1'b0);
      check($sformatf("rr_all_%0d", i), int'(last_ready), 1 << (i % 4));
    end
    for (int i = 0; i < 6; i++) begin
      int exp_ch;
      cycle(4'b1101, 4'b0000, 1'b0, '0, 1'b0);
      exp_ch = (i % 3 == 0) ? 0 : (i % 3 == 1) ? 2 : 3;
      check($sformatf("rr_skip1_%0d", i), int'(last_ready), 1 << exp_ch);
    end

    // Independent contexts: channels 0 and 2 interleaved, each sending 1010.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send((i % 2 == 0) ? 0 : 2, b4[i / 2]);
      pulses += int'(match[0]);
      if (i == 6) check("ic_match0", int'(match[0]), 1);
      if (i == 7) check("ic_match2", int'(match[2]), 1);
    end
    check("ic_pulses0", pulses, 1);
    check("ic_hit0", int'(hit_cnt[0 +: CNT_W]), 1);
    check("ic_hit2", int'(hit_cnt[2*CNT_W +: CNT_W]), 1);

    // Reconfiguration mid-stream.
    do_reset();
    send(0, 1'b1); send(0, 1'b0); send(0, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b1, 4'b1100, 1'b0);
    check("rc_ready_on_load", int'(last_ready), 0);
    send(0, 1'b0); check("rc_after0", int'(match[0]), 0);
    send(0, 1'b1); check("rc_after1a", int'(match[0]), 0);
    send(0, 1'b1); check("rc_after1b", int'(match[0]), 0);
    send(0, 1'b0); check("rc_after0a", int'(match[0]), 0);
    send(0, 1'b0); check("rc_after0b", int'(match[0]), 1);

    // Saturation, then clear coincident with a match.
    cycle(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b0);
    for (int i = 0; i < 262; i++) send(0, 1'b1);
    check("sat_hit0", int'(hit_cnt[0 +: CNT_W]), 255);
    check("sat_match0", int'(match[0]), 1);
    cycle(4'b0001, 4'b0001, 1'b0, '0, 1'b1);
    check("clr_match0", int'(match[0]), 1);
    check("clr_hit0", int'(hit_cnt[0 +: CNT_W]), 0);

    // Async reset between edges with live history and a pending request.
    send(0, 1'b1);
    check("ar_pre_match", int'(match[0]), 1);
    req_valid = 4'b0001; req_bit = 4'b0001;
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("ar_match", int'(match), 0);
    check("ar_hit_cnt", int'(hit_cnt), 0);
    check("ar_ready", int'(req_ready), 0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    send(0, 1'b0); check("ar_post0", int'(match[0]), 0);
    send(0, 1'b1); send(0, 1'b0); send(0, 1'b1);
    check("ar_post_partial", int'(match[0]), 0);
    send(0, 1'b0); check("ar_default_pat", int'(match[0]), 1);

    // Randomized traffic honouring hold-until-transfer.
    pv = '0; pb = '0;
    for (int n = 0; n < 700; n++) begin
      logic ld;
      logic clr;
      for (int k = 0; k < NCH; k++) begin
        if (!pv[k] && $urandom_range(0, 99) < 60) begin
          pv[k] = 1'b1;
          pb[k] = 1'($urandom_range(0, 1));
        end
      end
      ld  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      rp  = PAT_W'($urandom);
      cycle(pv, pb, ld, rp, clr);
      pv = pv & ~m_ready;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
